// File: rtl/uart_rx_16x_if.sv
// uart_rx_16x: byte handshake between the receiver and its consumer.
// The receiver drives data and flags; the consumer returns the acknowledge.
interface uart_rx_16x_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] DATA_OUT;
  logic                 DATA_VALID;
  logic                 DATA_ACK;
  logic                 FRAME_ERR;
  logic                 OVERRUN;

  modport master (
    output DATA_OUT,
    output DATA_VALID,
    output FRAME_ERR,
    output OVERRUN,
    input  DATA_ACK
  );

  modport slave (
    input  DATA_OUT,
    input  DATA_VALID,
    input  FRAME_ERR,
    input  OVERRUN,
    output DATA_ACK
  );
endinterface

// File: rtl/uart_rx_16x.sv
// uart_rx_16x: UART receiver on a 16x baud tick, mid-bit sampling,
// stop-bit check, valid/ack handshake with framing and overrun flags.
module uart_rx_16x #(
  parameter int DATA_BITS  = 8,
  parameter int MID_SAMPLE = 7
) (
  input  logic CLK,
  input  logic RESET,
  input  logic BAUD_TICK,
  input  logic RX,
  output logic BUSY,
  uart_rx_16x_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  localparam logic [3:0] MID  = 4'(MID_SAMPLE);
  localparam logic [2:0] LAST = 3'(DATA_BITS - 1);

  state_t state, state_n;

  logic                 rx_m, rx_s;
  logic [3:0]           tick_cnt, tick_n;
  logic [2:0]           bit_cnt, bit_n;
  logic [DATA_BITS-1:0] sr, sr_n;
  logic [DATA_BITS-1:0] dout_n;
  logic                 valid_n, ferr_n, ovr_n;
  logic                 good, bad, ack_v, last_tick;

  assign last_tick = (tick_cnt == 4'hf);
  assign BUSY      = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rx_m           <= 1'b1;
      rx_s           <= 1'b1;
      state          <= IDLE;
      tick_cnt       <= '0;
      bit_cnt        <= '0;
      sr             <= '0;
      bus.DATA_OUT   <= '0;
      bus.DATA_VALID <= 1'b0;
      bus.FRAME_ERR  <= 1'b0;
      bus.OVERRUN    <= 1'b0;
    end else begin
      rx_m           <= RX;
      rx_s           <= rx_m;
      state          <= state_n;
      tick_cnt       <= tick_n;
      bit_cnt        <= bit_n;
      sr             <= sr_n;
      bus.DATA_OUT   <= dout_n;
      bus.DATA_VALID <= valid_n;
      bus.FRAME_ERR  <= ferr_n;
      bus.OVERRUN    <= ovr_n;
    end
  end

  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    sr_n    = sr;
    good    = 1'b0;
    bad     = 1'b0;
    if (BAUD_TICK) begin
      tick_n = tick_cnt + 4'd1;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state_n = START;
            tick_n  = '0;
          end
        end
        START: begin
          if (tick_cnt == MID) begin
            tick_n = '0;
            bit_n  = '0;
            state_n = rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (last_tick) begin
            sr_n  = {rx_s, sr[DATA_BITS-1:1]};
            bit_n = bit_cnt + 3'd1;
            if (bit_cnt == LAST) begin
              state_n = STOP;
              tick_n  = '0;
            end
          end
        end
        STOP: begin
          if (last_tick) begin
            good    = rx_s;
            bad     = !rx_s;
            state_n = rx_s ? IDLE : WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // A coincident ack retires the old byte, so the new one never overruns.
  always_comb begin
    dout_n  = bus.DATA_OUT;
    valid_n = bus.DATA_VALID;
    ovr_n   = bus.OVERRUN;
    ferr_n  = bad;
    ack_v   = bus.DATA_ACK && bus.DATA_VALID;
    if (good) begin
      dout_n  = sr;
      valid_n = 1'b1;
    end else if (ack_v) begin
      valid_n = 1'b0;
    end
    if (ack_v) begin
      ovr_n = 1'b0;
    end else if (good && bus.DATA_VALID) begin
      ovr_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_16x.sv
// tb_uart_rx_16x: table-driven frames plus scoreboard on two receivers
// (8-bit with tick every 4 clocks, 5-bit with tick every clock).
module tb_uart_rx_16x;

  typedef struct {
    logic [7:0] d;
    int         stop_ticks;
    bit         ack;
    bit         exp_ovr;
  } vec_t;

  typedef struct {
    bit         ferr;
    logic [7:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic tick_a, tick_b;
  logic rx_a, rx_b;
  logic busy_a, busy_b;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  uart_rx_16x_if #(.DATA_BITS(8)) ifa ();
  uart_rx_16x_if #(.DATA_BITS(5)) ifb ();

  uart_rx_16x #(.DATA_BITS(8), .MID_SAMPLE(7)) dut_a (
    .CLK       (clk),
    .RESET     (rst_a),
    .BAUD_TICK (tick_a),
    .RX        (rx_a),
    .BUSY      (busy_a),
    .bus       (ifa)
  );

  uart_rx_16x #(.DATA_BITS(5), .MID_SAMPLE(7)) dut_b (
    .CLK       (clk),
    .RESET     (rst_b),
    .BAUD_TICK (tick_b),
    .RX        (rx_b),
    .BUSY      (busy_b),
    .bus       (ifb)
  );

  always #5 clk = ~clk;

  initial begin
    int ph;
    ph = 0;
    tick_a = 1'b0;
    forever begin
      @(negedge clk);
      tick_a = (ph == 0);
      ph = (ph + 1) % 4;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int w, input bit f, input logic [7:0] d);
    exp_t e;
    e.ferr = f;
    e.d    = d;
    if (w == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  task automatic sb_pop(input int w, input bit f, input logic [7:0] d);
    exp_t e;
    bit   empty;
    empty = (w == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
    if (empty) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb%0d unexpected: ferr=%0b data=%0h", w, f, d);
    end else begin
      if (w == 0) e = q_a.pop_front();
      else        e = q_b.pop_front();
      chk($sformatf("sb%0d_ferr", w), 32'(f), 32'(e.ferr));
      if (!f) chk($sformatf("sb%0d_data", w), 32'(d), 32'(e.d));
    end
  endtask

  initial begin
    logic       pv;
    logic [7:0] pd;
    pv = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (rst_a) begin
        pv = 1'b0;
        pd = '0;
      end else begin
        if (ifa.FRAME_ERR === 1'b1) sb_pop(0, 1'b1, 8'h00);
        if ((ifa.DATA_VALID === 1'b1 && !pv) || ifa.DATA_OUT !== pd)
          sb_pop(0, 1'b0, ifa.DATA_OUT);
        pv = ifa.DATA_VALID;
        pd = ifa.DATA_OUT;
      end
    end
  end

  initial begin
    logic       pv;
    logic [7:0] pd;
    pv = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (rst_b) begin
        pv = 1'b0;
        pd = '0;
      end else begin
        if (ifb.FRAME_ERR === 1'b1) sb_pop(1, 1'b1, 8'h00);
        if ((ifb.DATA_VALID === 1'b1 && !pv) ||
            {3'b0, ifb.DATA_OUT} !== pd)
          sb_pop(1, 1'b0, {3'b0, ifb.DATA_OUT});
        pv = ifb.DATA_VALID;
        pd = {3'b0, ifb.DATA_OUT};
      end
    end
  end

  task automatic set_rx(input int w, input logic v);
    if (w == 0) rx_a = v;
    else        rx_b = v;
  endtask

  task automatic wait_t(input int w, input int n);
    repeat (n * ((w == 0) ? 4 : 1)) @(negedge clk);
  endtask

  task automatic send(input int w, input logic [7:0] d, input int nb,
                      input int stop_ticks, input logic stop_v);
    set_rx(w, 1'b0);
    wait_t(w, 16);
    for (int i = 0; i < nb; i++) begin
      set_rx(w, d[i]);
      wait_t(w, 16);
    end
    set_rx(w, stop_v);
    wait_t(w, stop_ticks);
  endtask

  task automatic ack_a_pulse();
    ifa.DATA_ACK = 1'b1;
    @(negedge clk);
    ifa.DATA_ACK = 1'b0;
  endtask

  task automatic chk_reset(input int w);
    if (w == 0) begin
      chk("a_rst_data",  32'(ifa.DATA_OUT),   0);
      chk("a_rst_valid", 32'(ifa.DATA_VALID), 0);
      chk("a_rst_ferr",  32'(ifa.FRAME_ERR),  0);
      chk("a_rst_ovr",   32'(ifa.OVERRUN),    0);
      chk("a_rst_busy",  32'(busy_a),         0);
    end else begin
      chk("b_rst_data",  32'(ifb.DATA_OUT),   0);
      chk("b_rst_valid", 32'(ifb.DATA_VALID), 0);
      chk("b_rst_ferr",  32'(ifb.FRAME_ERR),  0);
      chk("b_rst_ovr",   32'(ifb.OVERRUN),    0);
      chk("b_rst_busy",  32'(busy_b),         0);
    end
  endtask

  initial begin
    vec_t vt[6];
    vt[0] = '{8'hA5, 16, 1'b1, 1'b0};
    vt[1] = '{8'h5A, 16, 1'b1, 1'b0};
    vt[2] = '{8'hFF, 16, 1'b1, 1'b0};
    vt[3] = '{8'h00, 16, 1'b1, 1'b0};
    vt[4] = '{8'h11, 11, 1'b0, 1'b0};
    vt[5] = '{8'h22, 16, 1'b1, 1'b1};

    rst_a = 1'b1;
    rst_b = 1'b1;
    tick_b = 1'b1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    ifa.DATA_ACK = 1'b0;
    ifb.DATA_ACK = 1'b0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    chk_reset(0);
    chk_reset(1);
    wait_t(0, 4);

    for (int i = 0; i < 6; i++) begin
      push(0, 1'b0, vt[i].d);
      send(0, vt[i].d, 8, vt[i].stop_ticks, 1'b1);
      chk($sformatf("a_v%0d_valid", i), 32'(ifa.DATA_VALID), 1);
      chk($sformatf("a_v%0d_data", i), 32'(ifa.DATA_OUT), 32'(vt[i].d));
      chk($sformatf("a_v%0d_ovr", i), 32'(ifa.OVERRUN),
          32'(vt[i].exp_ovr));
      if (vt[i].ack) begin
        ack_a_pulse();
        chk($sformatf("a_v%0d_ack_valid", i), 32'(ifa.DATA_VALID), 0);
        chk($sformatf("a_v%0d_ack_ovr", i), 32'(ifa.OVERRUN), 0);
      end
    end

    set_rx(0, 1'b0);
    wait_t(0, 3);
    chk("a_glitch_busy", 32'(busy_a), 1);
    wait_t(0, 2);
    set_rx(0, 1'b1);
    wait_t(0, 16);
    chk("a_glitch_idle", 32'(busy_a), 0);
    chk("a_glitch_valid", 32'(ifa.DATA_VALID), 0);

    push(0, 1'b1, 8'h00);
    send(0, 8'h3C, 8, 20, 1'b0);
    chk("a_brk_busy", 32'(busy_a), 1);
    chk("a_brk_valid", 32'(ifa.DATA_VALID), 0);
    wait_t(0, 20);
    chk("a_brk_hold", 32'(busy_a), 1);
    set_rx(0, 1'b1);
    wait_t(0, 8);
    chk("a_brk_idle", 32'(busy_a), 0);
    push(0, 1'b0, 8'h81);
    send(0, 8'h81, 8, 16, 1'b1);
    chk("a_81_valid", 32'(ifa.DATA_VALID), 1);
    chk("a_81_data", 32'(ifa.DATA_OUT), 32'h81);
    ack_a_pulse();

    push(1, 1'b0, 8'h15);
    send(1, 8'h15, 5, 16, 1'b1);
    chk("b_15_valid", 32'(ifb.DATA_VALID), 1);
    chk("b_15_data", 32'(ifb.DATA_OUT), 32'h15);

    set_rx(1, 1'b0);
    wait_t(1, 16);
    set_rx(1, 1'b0);
    wait_t(1, 16);
    set_rx(1, 1'b1);
    wait_t(1, 16);
    set_rx(1, 1'b0);
    wait_t(1, 8);
    rst_b = 1'b1;
    rx_b = 1'b1;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    chk_reset(1);
    wait_t(1, 150);
    chk("b_abort_valid", 32'(ifb.DATA_VALID), 0);
    chk("b_abort_busy", 32'(busy_b), 0);

    push(1, 1'b0, 8'h0C);
    send(1, 8'h0C, 5, 16, 1'b1);
    push(1, 1'b0, 8'h1E);
    send(1, 8'h1E, 5, 16, 1'b1);
    chk("b_1e_data", 32'(ifb.DATA_OUT), 32'h1E);
    chk("b_1e_ovr", 32'(ifb.OVERRUN), 1);

    push(1, 1'b0, 8'h13);
    fork
      send(1, 8'h13, 5, 16, 1'b1);
      begin
        repeat (106) @(negedge clk);
        chk("b_pre_valid", 32'(ifb.DATA_VALID), 1);
        ifb.DATA_ACK = 1'b1;
        @(negedge clk);
        ifb.DATA_ACK = 1'b0;
      end
    join
    chk("b_co_valid", 32'(ifb.DATA_VALID), 1);
    chk("b_co_data", 32'(ifb.DATA_OUT), 32'h13);
    chk("b_co_ovr", 32'(ifb.OVERRUN), 0);
    ifb.DATA_ACK = 1'b1;
    @(negedge clk);
    ifb.DATA_ACK = 1'b0;
    chk("b_end_valid", 32'(ifb.DATA_VALID), 0);

    wait_t(0, 4);
    chk("a_sb_empty", 32'(q_a.size()), 0);
    chk("b_sb_empty", 32'(q_b.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
